knap_search_ctrl: RTL and testbench

Exhaustive-search sequencer for the knapsack feasibility check. On `start` it snapshots a problem instance of N items with value, weight and volume plus three limits. It then steps one candidate selection mask per clock through an internal evaluator that uses the same rule as the multi-constraint validity checker: value ≥ min, weight ≤ max, volume ≤ max. It reports the best feasible selection with a start/busy/done handshake, so the host compares hardware results against the annealer's answers.

---
 rtl/knap_search_ctrl_if.sv | 43 ++++
 rtl/knap_search_ctrl.sv | 176 +++++++++++++++++
 tb/tb_knap_search_ctrl.sv | 370 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/knap_search_ctrl_if.sv
// ============================================================================
// knap_search_ctrl_if
// Host <-> search-controller bundle: start request, problem snapshot inputs,
// busy/done handshake and the best-solution results.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface knap_search_ctrl_if #(
  parameter int N_ITEMS = 5,
  parameter int W       = 5
);
  // Request and problem instance (host drives)
  logic                 start;
  logic [N_ITEMS*W-1:0] item_value;
  logic [N_ITEMS*W-1:0] item_weight;
  logic [N_ITEMS*W-1:0] item_volume;
  logic [W-1:0]         min_value;
  logic [W-1:0]         max_weight;
  logic [W-1:0]         max_volume;

  // Handshake and results (controller drives)
  logic                 busy;
  logic                 done;
  logic                 found;
  logic [N_ITEMS-1:0]   best_mask;
  logic [W+2:0]         best_value;
  logic [N_ITEMS:0]     valid_count;

  modport master (
    output start, item_value, item_weight, item_volume,
           min_value, max_weight, max_volume,
    input  busy, done, found, best_mask, best_value, valid_count
  );

  modport slave (
    input  start, item_value, item_weight, item_volume,
           min_value, max_weight, max_volume,
    output busy, done, found, best_mask, best_value, valid_count
  );
endinterface

`default_nettype wire

// File: rtl/knap_search_ctrl.sv
// ============================================================================
// knap_search_ctrl
// Exhaustive knapsack feasibility search: snapshots the instance on start,
// evaluates one selection mask per clock (value >= min, weight <= max,
// volume <= max) and reports the best feasible selection.
// Optional feature macro: KNAP_COUNT_EN (builds the feasible-mask counter;
// when undefined valid_count is tied to 0).
// Revision: 1.0
// ============================================================================
`default_nettype none

module knap_search_ctrl #(
  parameter int N_ITEMS = 5,
  parameter int W       = 5
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  knap_search_ctrl_if.slave    bus
);

  // Sums carry three guard bits so up to 8 items can never wrap.
  localparam int SW = W + 3;
  localparam logic [N_ITEMS-1:0] LAST_MASK = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t state;

  // Candidate selection currently being evaluated
  logic [N_ITEMS-1:0]   mask;

  // Snapshot of the problem taken when start is accepted
  logic [N_ITEMS*W-1:0] snap_value;
  logic [N_ITEMS*W-1:0] snap_weight;
  logic [N_ITEMS*W-1:0] snap_volume;
  logic [W-1:0]         snap_min_value;
  logic [W-1:0]         snap_max_weight;
  logic [W-1:0]         snap_max_volume;

  // Registered handshake and results
  logic                 scan_busy;
  logic                 done_pulse;
  logic                 found_any;
  logic [N_ITEMS-1:0]   best_sel;
  logic [SW-1:0]        best_sum;

  // Evaluation of the current mask
  logic [SW-1:0]        sum_value;
  logic [SW-1:0]        sum_weight;
  logic [SW-1:0]        sum_volume;
  logic                 feasible;
  logic                 better;
  logic                 start_accept;

  assign start_accept = (state == ST_IDLE) && bus.start;

  // Sum the selected items of the snapshot and test all three limits
  always_comb begin
    sum_value  = '0;
    sum_weight = '0;
    sum_volume = '0;
    for (int i = 0; i < N_ITEMS; i++) begin
      if (mask[i]) begin
        sum_value  = sum_value  + SW'(snap_value [i*W +: W]);
        sum_weight = sum_weight + SW'(snap_weight[i*W +: W]);
        sum_volume = sum_volume + SW'(snap_volume[i*W +: W]);
      end
    end
    feasible = (sum_value  >= SW'(snap_min_value))  &&
               (sum_weight <= SW'(snap_max_weight)) &&
               (sum_volume <= SW'(snap_max_volume));
    // Masks are visited in ascending order, so a strict compare keeps the
    // lowest mask among equal-value solutions.
    better   = !found_any || (sum_value > best_sum);
  end

  // Sequencer: snapshot on start, one mask per cycle, one-cycle done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      mask            <= '0;
      snap_value      <= '0;
      snap_weight     <= '0;
      snap_volume     <= '0;
      snap_min_value  <= '0;
      snap_max_weight <= '0;
      snap_max_volume <= '0;
      scan_busy       <= 1'b0;
      done_pulse      <= 1'b0;
      found_any       <= 1'b0;
      best_sel        <= '0;
      best_sum        <= '0;
    end else begin
      done_pulse <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            snap_value      <= bus.item_value;
            snap_weight     <= bus.item_weight;
            snap_volume     <= bus.item_volume;
            snap_min_value  <= bus.min_value;
            snap_max_weight <= bus.max_weight;
            snap_max_volume <= bus.max_volume;
            found_any       <= 1'b0;
            best_sel        <= '0;
            best_sum        <= '0;
            mask            <= '0;
            scan_busy       <= 1'b1;
            state           <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (feasible) begin
            found_any <= 1'b1;
            if (better) begin
              best_sel <= mask;
              best_sum <= sum_value;
            end
          end
          // Stop after the all-ones mask instead of wrapping to a second pass
          if (mask == LAST_MASK) begin
            done_pulse <= 1'b1;
            state      <= ST_DONE;
          end else begin
            mask <= mask + 1'b1;
          end
        end
        ST_DONE: begin
          scan_busy <= 1'b0;
          state     <= ST_IDLE;
        end
        default: begin
          scan_busy <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef KNAP_COUNT_EN
  // Saturation point: every one of the 2^N masks feasible
  localparam logic [N_ITEMS:0] COUNT_MAX = {1'b1, {N_ITEMS{1'b0}}};

  logic [N_ITEMS:0] feasible_count;

  // Count feasible masks of the running search; cleared on start accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      feasible_count <= '0;
    end else if (start_accept) begin
      feasible_count <= '0;
    end else if ((state == ST_SCAN) && feasible && (feasible_count != COUNT_MAX)) begin
      feasible_count <= feasible_count + 1'b1;
    end
  end

  assign bus.valid_count = feasible_count;
`else
  logic unused_accept;
  assign unused_accept   = start_accept;
  assign bus.valid_count = '0;
`endif

  assign bus.busy       = scan_busy;
  assign bus.done       = done_pulse;
  assign bus.found      = found_any;
  assign bus.best_mask  = best_sel;
  assign bus.best_value = best_sum;

endmodule

`default_nettype wire

// File: tb/tb_knap_search_ctrl.sv
// ============================================================================
// tb_knap_search_ctrl
// Self-checking bench for knap_search_ctrl: directed plan cases, randomized
// instances against a brute-force reference, snapshot isolation, mid-scan
// reset and back-to-back searches.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_knap_search_ctrl;

  localparam int N  = 5;
  localparam int W  = 5;
  localparam int LAT = 33;   // cycle (counting the one after E0 as 1) with done high

`ifdef KNAP_COUNT_EN
  localparam bit COUNT_ON = 1'b1;
`else
  localparam bit COUNT_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  knap_search_ctrl_if #(.N_ITEMS(N), .W(W)) bus ();

  knap_search_ctrl #(.N_ITEMS(N), .W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Problem instance as plain integers
  int val_a [N];
  int wt_a  [N];
  int vol_a [N];
  int min_v, max_w, max_vol;

  // Reference results
  logic         exp_found;
  logic [N-1:0] exp_mask;
  logic [W+2:0] exp_value;
  logic [N:0]   exp_count;

  // Observed results
  logic         obs_found;
  logic [N-1:0] obs_mask;
  logic [W+2:0] obs_value;
  logic [N:0]   obs_count;
  logic         obs_busy_first;
  logic         obs_busy_after;

  task automatic apply_inputs();
    for (int i = 0; i < N; i++) begin
      bus.item_value [i*W +: W] = val_a[i][W-1:0];
      bus.item_weight[i*W +: W] = wt_a[i][W-1:0];
      bus.item_volume[i*W +: W] = vol_a[i][W-1:0];
    end
    bus.min_value  = min_v[W-1:0];
    bus.max_weight = max_w[W-1:0];
    bus.max_volume = max_vol[W-1:0];
  endtask

  // Brute force over all subsets with integer arithmetic
  task automatic model();
    int sv, sw, so, cnt;
    exp_found = 1'b0;
    exp_mask  = '0;
    exp_value = '0;
    cnt = 0;
    for (int m = 0; m < (1 << N); m++) begin
      sv = 0; sw = 0; so = 0;
      for (int i = 0; i < N; i++) begin
        if (((m >> i) & 1) == 1) begin
          sv += val_a[i]; sw += wt_a[i]; so += vol_a[i];
        end
      end
      if (sv >= min_v && sw <= max_w && so <= max_vol) begin
        cnt++;
        if (!exp_found || sv > int'(exp_value)) begin
          exp_found = 1'b1;
          exp_mask  = N'(m);
          exp_value = (W+3)'(sv);
        end
      end
    end
    exp_count = COUNT_ON ? (N+1)'(cnt) : '0;
  endtask

  task automatic randomize_arrays(input int mode);
    for (int i = 0; i < N; i++) begin
      if (mode == 0) begin
        val_a[i] = $urandom_range(0, 31);
        wt_a[i]  = $urandom_range(0, 31);
        vol_a[i] = $urandom_range(0, 31);
      end else begin
        val_a[i] = $urandom_range(1, 4);
        wt_a[i]  = $urandom_range(0, 3);
        vol_a[i] = $urandom_range(0, 3);
      end
    end
    min_v   = (mode == 0) ? $urandom_range(0, 31) : $urandom_range(0, 8);
    max_w   = (mode == 0) ? $urandom_range(10, 31) : $urandom_range(0, 6);
    max_vol = (mode == 0) ? $urandom_range(10, 31) : $urandom_range(0, 6);
  endtask

  // Launch one search and follow it to idle; optional disturbance mid-scan
  task automatic run_search(input bit disturb, output int lat, output int done_cnt);
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    lat = 0;
    done_cnt = 0;
    obs_busy_first = bus.busy;
    obs_busy_after = 1'b1;
    for (int c = 1; c <= 80; c++) begin
      if (bus.done) begin
        done_cnt++;
        if (lat == 0) lat = c;
      end
      if (lat != 0 && c == lat + 1) obs_busy_after = bus.busy;
      if (disturb && c == 6) begin
        bus.start       = 1'b1;
        bus.item_value  = N*W'($urandom);
        bus.item_weight = N*W'($urandom);
        bus.item_volume = N*W'($urandom);
        bus.min_value   = W'($urandom);
        bus.max_weight  = W'($urandom);
        bus.max_volume  = W'($urandom);
      end
      if (disturb && c == 9) bus.start = 1'b0;
      if (lat != 0 && c >= lat + 2) break;
      @(posedge clk);
      #1;
    end
    obs_found = bus.found;
    obs_mask  = bus.best_mask;
    obs_value = bus.best_value;
    obs_count = bus.valid_count;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0;
    apply_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    tests_run++;
    if ({bus.busy, bus.done, bus.found} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_flags busy/done/found=%b required 000", {bus.busy, bus.done, bus.found});
    end
    tests_run++;
    if (bus.best_mask !== '0 || bus.best_value !== '0 || bus.valid_count !== '0) begin
      tests_failed++;
      $display("FAIL reset_results mask=%b value=%0d count=%0d required 0/0/0",
               bus.best_mask, bus.best_value, bus.valid_count);
    end
  endtask

  // Plan cases with hand-derived answers
  task automatic test_directed();
    int lat, dc;
    logic         req_found;
    logic [N-1:0] req_mask;
    logic [W+2:0] req_value;
    logic [N:0]   req_count;
    for (int k = 0; k < 4; k++) begin
      val_a = '{4, 2, 2, 1, 10};
      wt_a  = '{12, 1, 2, 1, 4};
      vol_a = '{1, 1, 1, 1, 1};
      case (k)
        0: begin min_v = 15; max_w = 16; max_vol = 5;
                 req_found = 1'b1; req_mask = 5'b11110; req_value = 8'd15; req_count = 6'd1; end
        1: begin min_v = 0;  max_w = 31; max_vol = 5;
                 req_found = 1'b1; req_mask = 5'b11111; req_value = 8'd19; req_count = 6'd32; end
        2: begin min_v = 20; max_w = 16; max_vol = 5;
                 req_found = 1'b0; req_mask = 5'b00000; req_value = 8'd0;  req_count = 6'd0; end
        default: begin
                 val_a = '{3, 3, 3, 3, 3};
                 wt_a  = '{1, 1, 1, 1, 1};
                 min_v = 3; max_w = 31; max_vol = 1;
                 req_found = 1'b1; req_mask = 5'b00001; req_value = 8'd3; req_count = 6'd5; end
      endcase
      if (!COUNT_ON) req_count = '0;
      apply_inputs();
      run_search(1'b0, lat, dc);
      tests_run++;
      if (obs_found !== req_found || obs_mask !== req_mask || obs_value !== req_value) begin
        tests_failed++;
        $display("FAIL directed%0d_best found=%b mask=%b value=%0d required %b/%b/%0d",
                 k, obs_found, obs_mask, obs_value, req_found, req_mask, req_value);
      end
      tests_run++;
      if (obs_count !== req_count) begin
        tests_failed++;
        $display("FAIL directed%0d_count got %0d required %0d", k, obs_count, req_count);
      end
      tests_run++;
      if (lat != LAT || dc != 1 || obs_busy_first !== 1'b1 || obs_busy_after !== 1'b0) begin
        tests_failed++;
        $display("FAIL directed%0d_timing done_at=%0d pulses=%0d busy_first=%b busy_after=%b required %0d/1/1/0",
                 k, lat, dc, obs_busy_first, obs_busy_after, LAT);
      end
    end
  endtask

  task automatic test_random();
    int lat, dc;
    for (int k = 0; k < 12; k++) begin
      randomize_arrays(k % 2);
      apply_inputs();
      model();
      run_search(1'b0, lat, dc);
      tests_run++;
      if (obs_found !== exp_found || obs_mask !== exp_mask || obs_value !== exp_value ||
          obs_count !== exp_count || lat != LAT || dc != 1) begin
        tests_failed++;
        $display("FAIL random%0d found=%b mask=%b value=%0d count=%0d done_at=%0d required %b/%b/%0d/%0d/%0d",
                 k, obs_found, obs_mask, obs_value, obs_count, lat,
                 exp_found, exp_mask, exp_value, exp_count, LAT);
      end
    end
  endtask

  // Inputs and start toggled after E0 must not disturb the running search
  task automatic test_snapshot();
    int lat, dc;
    randomize_arrays(1);
    min_v = 2;
    apply_inputs();
    model();
    run_search(1'b1, lat, dc);
    tests_run++;
    if (obs_found !== exp_found || obs_mask !== exp_mask || obs_value !== exp_value ||
        obs_count !== exp_count) begin
      tests_failed++;
      $display("FAIL snapshot found=%b mask=%b value=%0d count=%0d required %b/%b/%0d/%0d",
               obs_found, obs_mask, obs_value, obs_count, exp_found, exp_mask, exp_value, exp_count);
    end
    tests_run++;
    if (dc != 1 || lat != LAT) begin
      tests_failed++;
      $display("FAIL snapshot_done pulses=%0d done_at=%0d required 1/%0d", dc, lat, LAT);
    end
  endtask

  task automatic test_reset_mid_scan();
    int lat, dc;
    bit done_seen;
    val_a = '{4, 2, 2, 1, 10};
    wt_a  = '{12, 1, 2, 1, 4};
    vol_a = '{1, 1, 1, 1, 1};
    min_v = 0; max_w = 31; max_vol = 5;
    apply_inputs();
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({bus.busy, bus.done, bus.found} !== 3'b000 || bus.best_mask !== '0 ||
        bus.best_value !== '0 || bus.valid_count !== '0) begin
      tests_failed++;
      $display("FAIL midscan_reset busy=%b done=%b found=%b mask=%b value=%0d count=%0d required all 0",
               bus.busy, bus.done, bus.found, bus.best_mask, bus.best_value, bus.valid_count);
    end
    done_seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) done_seen = 1'b1;
      if (c == 2) rst_n = 1'b1;
    end
    tests_run++;
    if (done_seen) begin
      tests_failed++;
      $display("FAIL midscan_no_done saw done/busy=1 required 0");
    end
    randomize_arrays(0);
    apply_inputs();
    model();
    run_search(1'b0, lat, dc);
    tests_run++;
    if (obs_found !== exp_found || obs_mask !== exp_mask || obs_value !== exp_value ||
        obs_count !== exp_count || lat != LAT) begin
      tests_failed++;
      $display("FAIL post_reset_search found=%b mask=%b value=%0d count=%0d done_at=%0d required %b/%b/%0d/%0d/%0d",
               obs_found, obs_mask, obs_value, obs_count, lat,
               exp_found, exp_mask, exp_value, exp_count, LAT);
    end
  endtask

  // Start held high: the next search begins in the first IDLE cycle after DONE
  task automatic test_back_to_back();
    int lat1, lat2;
    randomize_arrays(1);
    apply_inputs();
    model();
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    lat1 = 0;
    for (int c = 1; c <= 60; c++) begin
      if (bus.done) begin lat1 = c; break; end
      @(posedge clk);
      #1;
    end
    tests_run++;
    if (lat1 != LAT || bus.found !== exp_found || bus.best_mask !== exp_mask ||
        bus.best_value !== exp_value || bus.valid_count !== exp_count) begin
      tests_failed++;
      $display("FAIL b2b_first done_at=%0d found=%b mask=%b value=%0d count=%0d required %0d/%b/%b/%0d/%0d",
               lat1, bus.found, bus.best_mask, bus.best_value, bus.valid_count,
               LAT, exp_found, exp_mask, exp_value, exp_count);
    end
    randomize_arrays(0);
    apply_inputs();
    model();
    lat2 = 0;
    for (int c = 1; c <= 80; c++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin lat2 = c; break; end
    end
    bus.start = 1'b0;
    tests_run++;
    if (lat2 != LAT + 1 || bus.found !== exp_found || bus.best_mask !== exp_mask ||
        bus.best_value !== exp_value || bus.valid_count !== exp_count) begin
      tests_failed++;
      $display("FAIL b2b_second interval=%0d found=%b mask=%b value=%0d count=%0d required %0d/%b/%b/%0d/%0d",
               lat2, bus.found, bus.best_mask, bus.best_value, bus.valid_count,
               LAT + 1, exp_found, exp_mask, exp_value, exp_count);
    end
    repeat (3) @(posedge clk);
  endtask

  initial begin
    val_a = '{0, 0, 0, 0, 0};
    wt_a  = '{0, 0, 0, 0, 0};
    vol_a = '{0, 0, 0, 0, 0};
    min_v = 0; max_w = 0; max_vol = 0;
    test_reset();
    test_directed();
    test_random();
    test_snapshot();
    test_reset_mid_scan();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire
